// File: rtl/fetch_prefetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue in front of decode.
// Latency: fetch request to valid queue head is IMEM_LAT+1 cycles; redirect to valid head is IMEM_LAT+2.
// Backpressure: StallD holds the head; issue stops once queued + in-flight entries reach DEPTH.
//
// Ports:
//   CLK, RESET           rising-edge clock, synchronous active-high reset
//   PCSrcE, PCTargetE    redirect from Execute (flush + new fetch PC)
//   StallD               decode not ready; the head is not popped
//   ImemReq, ImemAddr    fetch request and its address (PCF)
//   ImemRData            instruction, valid IMEM_LAT cycles after a request
//   ValidD, InstrD       queue head valid / instruction (NOP when empty)
//   PCD, PCPlus4D        PC of the head and PC+4
//   Occupancy            number of queued entries
module fetch_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_LAT = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     PCSrcE,
  input  logic [XLEN-1:0]          PCTargetE,
  input  logic                     StallD,
  output logic                     ImemReq,
  output logic [XLEN-1:0]          ImemAddr,
  input  logic [31:0]              ImemRData,
  output logic                     ValidD,
  output logic [31:0]              InstrD,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D,
  output logic [$clog2(DEPTH):0]   Occupancy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          SW      = AW + 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [IMEM_LAT-1:0] trk_q, trk_d;
  logic [XLEN-1:0] pc_sh_q [IMEM_LAT];
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [SW-1:0]   inflight;
  logic            push, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign Occupancy = wr_q - rd_q;
  assign ValidD    = (Occupancy != '0);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < IMEM_LAT; i++) begin
      inflight = inflight + SW'(trk_q[i]);
    end
  end

  // Credits count queued plus in-flight entries; a same-cycle pop is deliberately
  // not counted, so every issued request is guaranteed a free slot on return.
  assign ImemReq  = ~RESET & ~PCSrcE & ((SW'(Occupancy) + inflight) < SW'(DEPTH));
  assign ImemAddr = pcf_q;

  // A response is accepted when its tracker bit leaves the shift register;
  // responses landing during a redirect or reset belong to the old stream.
  assign push = trk_q[IMEM_LAT-1] & ~PCSrcE & ~RESET;
  assign pop  = ValidD & ~StallD & ~PCSrcE;

  assign InstrD   = ValidD ? instr_mem[rd_q[AW-1:0]] : NOP;
  assign PCD      = ValidD ? pc_mem[rd_q[AW-1:0]] : '0;
  assign PCPlus4D = PCD + XLEN'(4);

  always_comb begin
    pcf_d = pcf_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    trk_d = '0;
    if (PCSrcE) begin
      // Redirect wins over everything: empty the queue, forget in-flight fetches.
      pcf_d = PCTargetE & ~XLEN'(3);
      wr_d  = '0;
      rd_d  = '0;
    end else begin
      if (ImemReq) pcf_d = pcf_q + XLEN'(4);
      if (push)    wr_d  = wr_q + PTR_ONE;
      if (pop)     rd_d  = rd_q + PTR_ONE;
      trk_d[0] = ImemReq;
      for (int i = 1; i < IMEM_LAT; i++) begin
        trk_d[i] = trk_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pcf_q <= RESET_PC;
      wr_q  <= '0;
      rd_q  <= '0;
      trk_q <= '0;
    end else begin
      pcf_q <= pcf_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      trk_q <= trk_d;
    end
  end

  // PC shadow runs alongside the tracker so each response meets its own fetch PC.
  always_ff @(posedge CLK) begin
    pc_sh_q[0] <= pcf_q;
    for (int i = 1; i < IMEM_LAT; i++) begin
      pc_sh_q[i] <= pc_sh_q[i-1];
    end
    if (push) begin
      instr_mem[wr_q[AW-1:0]] <= ImemRData;
      pc_mem[wr_q[AW-1:0]]    <= pc_sh_q[IMEM_LAT-1];
    end
  end

endmodule
